// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for fetch/load/store requests.
// Serves one request at a time over a req/ack handshake. A fixed number of
// wait states sits between accepting a request and acknowledging it. The RAM
// is accessed on the clock edge that enters RESP, and ack/err/rdata are
// registered, so all three are valid together for the single RESP cycle.
module mem_responder #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 10,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              err,
    output logic              busy
);

    localparam int              MEM_AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0]      WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(MEM_DEPTH);

    // The wait counter is 4 bits, and the RAM cannot exceed the address space.
    generate
        if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
            $error("mem_responder: WAIT_CYCLES must be in 0..15");
        end
        if (MEM_DEPTH < 1 || MEM_DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
            $error("mem_responder: MEM_DEPTH must be in 1..2**ADDR_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic                enter_resp;
    logic [3:0]          cnt_reg;
    logic                we_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [DATA_W-1:0]   rdata_reg;
    logic                ack_reg;
    logic                err_reg;

    logic [DATA_W-1:0]   mem [0:MEM_DEPTH-1];

    // With zero wait states, RESP is entered on the acceptance edge itself,
    // before the request is captured. The access therefore uses the live
    // inputs while in IDLE and the captured copy otherwise.
    logic                acc_we;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_wdata;
    logic                in_range;
    logic [MEM_AW-1:0]   mem_idx;

    assign acc_we    = (state_reg == IDLE) ? we    : we_reg;
    assign acc_addr  = (state_reg == IDLE) ? addr  : addr_reg;
    assign acc_wdata = (state_reg == IDLE) ? wdata : wdata_reg;
    assign in_range  = ({1'b0, acc_addr} < DEPTH_LIM);
    assign mem_idx   = acc_addr[MEM_AW-1:0];

    // State register; an asynchronous reset aborts any request in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and the strobe that marks the edge entering RESP.
    always_comb begin
        state_next = state_reg;
        enter_resp = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    if (WAIT_INIT == 4'd0) begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg <= 4'd1) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request capture, wait counter and the registered response outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg   <= 4'd0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            ack_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            if (state_reg == IDLE && req) begin
                we_reg    <= we;
                addr_reg  <= addr;
                wdata_reg <= wdata;
                cnt_reg   <= WAIT_INIT;
            end else if (state_reg == WAIT) begin
                cnt_reg <= cnt_reg - 4'd1;
            end
            ack_reg <= enter_resp;
            err_reg <= enter_resp && !in_range;
            if (enter_resp && !acc_we) begin
                rdata_reg <= in_range ? mem[mem_idx] : '0;
            end
        end
    end

    // RAM write port. It has no reset, so the contents survive a reset.
    always_ff @(posedge clk) begin
        if (enter_resp && acc_we && in_range) begin
            mem[mem_idx] <= acc_wdata;
        end
    end

    assign rdata = rdata_reg;
    assign ack   = ack_reg;
    assign err   = err_reg;
    assign busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder. Instance 0 runs with zero wait states and
// full depth. Instance 1 runs with one wait state and a 512-word RAM.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_v   [2];
    logic        we_v    [2];
    logic [9:0]  addr_v  [2];
    logic [15:0] wdata_v [2];
    logic [15:0] rdata_v [2];
    logic        ack_v   [2];
    logic        err_v   [2];
    logic        busy_v  [2];

    int errors = 0;
    int checks = 0;

    // Edges from presenting req to ack visible, counting the acceptance edge.
    int lat_exp [2] = '{1, 2};

    always #5 clk = ~clk;

    mem_responder #(.DATA_W(16), .ADDR_W(10), .MEM_DEPTH(1024), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset(reset), .req(req_v[0]), .we(we_v[0]), .addr(addr_v[0]),
        .wdata(wdata_v[0]), .rdata(rdata_v[0]), .ack(ack_v[0]), .err(err_v[0]), .busy(busy_v[0])
    );

    mem_responder #(.DATA_W(16), .ADDR_W(10), .MEM_DEPTH(512), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .reset(reset), .req(req_v[1]), .we(we_v[1]), .addr(addr_v[1]),
        .wdata(wdata_v[1]), .rdata(rdata_v[1]), .ack(ack_v[1]), .err(err_v[1]), .busy(busy_v[1])
    );

    typedef struct packed {
        logic        we;
        logic [9:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [0:10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One complete handshake: present the request, wait (bounded) for ack,
    // check latency/rdata/err/busy, drop req, then confirm the return to IDLE.
    task automatic do_req(input int idx, input logic we_i, input logic [9:0] a,
                          input logic [15:0] d, input logic [15:0] exp_rd,
                          input logic exp_err, input string nm, output logic [15:0] rd_o);
        int  n;
        bit  seen;
        @(negedge clk);
        req_v[idx]   = 1'b1;
        we_v[idx]    = we_i;
        addr_v[idx]  = a;
        wdata_v[idx] = d;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 16) begin
            @(posedge clk);
            #1;
            n++;
            if (ack_v[idx] === 1'b1) seen = 1'b1;
            else chk({nm, " busy_wait"}, {31'd0, busy_v[idx]}, 32'd1);
        end
        chk({nm, " latency"}, n, lat_exp[idx]);
        chk({nm, " rdata"}, {16'd0, rdata_v[idx]}, {16'd0, exp_rd});
        chk({nm, " err"}, {31'd0, err_v[idx]}, {31'd0, exp_err});
        chk({nm, " busy_resp"}, {31'd0, busy_v[idx]}, 32'd1);
        rd_o = rdata_v[idx];
        @(negedge clk);
        req_v[idx] = 1'b0;
        @(posedge clk);
        #1;
        chk({nm, " idle_busy"}, {31'd0, busy_v[idx]}, 32'd0);
        chk({nm, " idle_ack"}, {31'd0, ack_v[idx]}, 32'd0);
        $display("txn %s: inst=%0d we=%0b addr=%h wdata=%h rdata=%h err=%0b lat=%0d",
                 nm, idx, we_i, a, d, rd_o, err_v[idx], n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd;
        logic [15:0] ir;
        logic [15:0] rf;
        int          k1, k2, nacks, extra;
        logic [15:0] r1, r2;
        bit          changed;

        for (int i = 0; i < 2; i++) begin
            req_v[i] = 1'b0; we_v[i] = 1'b0; addr_v[i] = '0; wdata_v[i] = '0;
        end

        // Reset state
        #12;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst%0d ack", i), {31'd0, ack_v[i]}, 32'd0);
            chk($sformatf("rst%0d err", i), {31'd0, err_v[i]}, 32'd0);
            chk($sformatf("rst%0d busy", i), {31'd0, busy_v[i]}, 32'd0);
            chk($sformatf("rst%0d rdata", i), {16'd0, rdata_v[i]}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Zero wait states: back-to-back loads with req held across the ack edge
        do_req(0, 1'b1, 10'h000, 16'h1111, 16'h0000, 1'b0, "w0_wr0", rd);
        do_req(0, 1'b1, 10'h001, 16'h2222, 16'h0000, 1'b0, "w0_wr1", rd);
        @(negedge clk);
        req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 10'h000;
        k1 = 0; k2 = 0; nacks = 0; changed = 1'b0; r1 = '0; r2 = '0;
        for (int k = 1; k <= 10 && nacks < 2; k++) begin
            @(posedge clk);
            #1;
            if (ack_v[0] === 1'b1) begin
                nacks++;
                if (nacks == 1) begin k1 = k; r1 = rdata_v[0]; end
                else begin k2 = k; r2 = rdata_v[0]; end
            end
            if (nacks == 1 && !changed) begin
                @(negedge clk);
                addr_v[0] = 10'h001;
                changed = 1'b1;
            end
        end
        @(negedge clk);
        req_v[0] = 1'b0;
        extra = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (ack_v[0] === 1'b1) extra++;
        end
        chk("b2b first_ack_cycle", k1, 1);
        chk("b2b ack_spacing", k2 - k1, 2);
        chk("b2b rdata0", {16'd0, r1}, 32'h1111);
        chk("b2b rdata1", {16'd0, r2}, 32'h2222);
        chk("b2b no_extra_ack", extra, 0);
        $display("txn b2b: acks at cycles %0d and %0d rdata %h %h", k1, k2, r1, r2);

        // One wait state, 512-word RAM: directed vector table
        tbl[0]  = '{1'b1, 10'h005, 16'hBEEF, 16'h0000, 1'b0};
        tbl[1]  = '{1'b0, 10'h005, 16'h0000, 16'hBEEF, 1'b0};
        tbl[2]  = '{1'b1, 10'h000, 16'h0F0F, 16'hBEEF, 1'b0};
        tbl[3]  = '{1'b1, 10'h200, 16'h1234, 16'hBEEF, 1'b1};
        tbl[4]  = '{1'b0, 10'h200, 16'h0000, 16'h0000, 1'b1};
        tbl[5]  = '{1'b0, 10'h000, 16'h0000, 16'h0F0F, 1'b0};
        tbl[6]  = '{1'b1, 10'h1FF, 16'hA5A5, 16'h0F0F, 1'b0};
        tbl[7]  = '{1'b0, 10'h1FF, 16'h0000, 16'hA5A5, 1'b0};
        tbl[8]  = '{1'b0, 10'h3FF, 16'h0000, 16'h0000, 1'b1};
        tbl[9]  = '{1'b1, 10'h010, 16'h5555, 16'h0000, 1'b0};
        tbl[10] = '{1'b0, 10'h010, 16'h0000, 16'h5555, 1'b0};
        for (int i = 0; i <= 10; i++) begin
            do_req(1, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd,
                   tbl[i].exp_err, $sformatf("vec%0d", i), rd);
        end

        // Reset pulsed in WAIT during a store of AAAA @ 0x010
        @(negedge clk);
        req_v[1] = 1'b1; we_v[1] = 1'b1; addr_v[1] = 10'h010; wdata_v[1] = 16'hAAAA;
        @(posedge clk);
        #1;
        chk("rstwait accepted_busy", {31'd0, busy_v[1]}, 32'd1);
        #2;
        reset = 1'b0;
        req_v[1] = 1'b0;
        #1;
        chk("rstwait ack", {31'd0, ack_v[1]}, 32'd0);
        chk("rstwait busy", {31'd0, busy_v[1]}, 32'd0);
        chk("rstwait rdata", {16'd0, rdata_v[1]}, 32'd0);
        @(posedge clk);
        #1;
        chk("rstwait held_ack", {31'd0, ack_v[1]}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        $display("txn rstwait: store aborted by reset");
        do_req(1, 1'b0, 10'h010, 16'h0000, 16'h5555, 1'b0, "rstwait_rd", rd);

        // Inputs toggled during WAIT: capture-time values win, one ack only
        do_req(1, 1'b1, 10'h021, 16'h1111, 16'h5555, 1'b0, "tog_pre", rd);
        @(negedge clk);
        req_v[1] = 1'b1; we_v[1] = 1'b1; addr_v[1] = 10'h020; wdata_v[1] = 16'h7777;
        @(posedge clk);
        #1;
        addr_v[1] = 10'h021; wdata_v[1] = 16'hFFFF; we_v[1] = 1'b0;
        nacks = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (ack_v[1] === 1'b1) begin
                nacks++;
                @(negedge clk);
                req_v[1] = 1'b0;
            end
        end
        chk("tog ack_count", nacks, 1);
        $display("txn tog: acks=%0d", nacks);
        do_req(1, 1'b0, 10'h020, 16'h0000, 16'h7777, 1'b0, "tog_rd20", rd);
        do_req(1, 1'b0, 10'h021, 16'h0000, 16'h1111, 1'b0, "tog_rd21", rd);

        // Control-FSM model: S0 fetch into IR, S4 load into the register file
        do_req(1, 1'b1, 10'h040, 16'h8050, 16'h1111, 1'b0, "cpu_prog", rd);
        do_req(1, 1'b1, 10'h050, 16'hC0DE, 16'h1111, 1'b0, "cpu_data", rd);
        chk("cpu idle_busy", {31'd0, busy_v[1]}, 32'd0);
        do_req(1, 1'b0, 10'h040, 16'h0000, 16'h8050, 1'b0, "cpu_S0_fetch", ir);
        do_req(1, 1'b0, {2'b00, ir[7:0]}, 16'h0000, 16'hC0DE, 1'b0, "cpu_S4_load", rf);
        chk("cpu ir", {16'd0, ir}, 32'h8050);
        chk("cpu regfile", {16'd0, rf}, 32'hC0DE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
